// File: rtl/alu_srcb_stage.sv
// Selects the ALU B operand from reg B, a constant or an immediate form, and registers it in a one-entry stage.
// Latency: an operand accepted on a rising edge is presented on out_data after that edge.
// Backpressure: in_ready = !out_valid || out_ready; the held operand is frozen while out_ready is low.
module alu_srcb_stage #(
    parameter int DATA_W    = 32,
    parameter int IMM_W     = 16,
    parameter int CONST_VAL = 4,
    parameter int SHIFT     = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        seletor,
    input  logic [DATA_W-1:0] reg_b_info,
    input  logic [IMM_W-1:0]  imm,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              sel_err,
    output logic              err_sticky
);

    localparam logic [DATA_W-1:0] CONST_D = DATA_W'(CONST_VAL);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              sel_err_q, sel_err_d;
    logic              err_sticky_q, err_sticky_d;

    logic [DATA_W-1:0] imm_sext, imm_shl, imm_zext, imm_upper;
    logic [DATA_W-1:0] dec_data;
    logic              dec_err;
    logic              accept;

    assign imm_sext  = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign imm_shl   = imm_sext << SHIFT;
    assign imm_zext  = {{(DATA_W-IMM_W){1'b0}}, imm};
    assign imm_upper = {imm, {(DATA_W-IMM_W){1'b0}}};

    always_comb begin
        dec_data = '0;
        dec_err  = 1'b0;
        case (seletor)
            3'd0:    dec_data = reg_b_info;
            3'd1:    dec_data = CONST_D;
            3'd2:    dec_data = imm_sext;
            3'd3:    dec_data = imm_shl;
            3'd4:    dec_data = imm_zext;
            3'd5:    dec_data = imm_upper;
            default: dec_err  = 1'b1;
        endcase
    end

    assign out_valid = (state_q == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        sel_err_d    = sel_err_q;
        err_sticky_d = err_sticky_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) state_d = ST_FULL;
            end
            ST_FULL: begin
                if (out_ready && !accept) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
        if (accept) begin
            out_data_d = dec_data;
            sel_err_d  = dec_err;
            if (dec_err) err_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_EMPTY;
            out_data_q   <= '0;
            sel_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            sel_err_q    <= sel_err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign out_data   = out_data_q;
    assign sel_err    = sel_err_q;
    assign err_sticky = err_sticky_q;

endmodule
